aes_job_arbiter: RTL and testbench

Two-requester scheduler that shares a single `AES_128` core. It arbitrates round-robin between two job ports and latches the winner's plaintext, key and direction. It sequences the core through hold-in-reset, run and capture, and returns the result on a valid/ready response port with a watchdog error flag. It sits between the bus-facing job queues and the core instance in the crypto subsystem top.

---
 rtl/aes_job_arbiter_pkg.sv | 20 ++
 rtl/aes_job_arbiter_if.sv | 44 ++++
 rtl/aes_job_arbiter_rr_arb2.sv | 15 +
 rtl/aes_job_arbiter.sv | 141 ++++++++++++++
 tb/tb_aes_job_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_job_arbiter_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES job arbiter.
//   AES_BLK_W          - AES block and key width in bits
//   TIMEOUT_CYCLES_DEF - default watchdog limit in RUN cycles
//   aes_ctrl_state_e   - arbiter sequencing states
//   aes_blk_t          - one 128-bit block or key
package aes_ctrl_pkg;

    localparam int unsigned AES_BLK_W          = 128;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StResp
    } aes_ctrl_state_e;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// aes_job_arbiter_if: job and response handshake bundle of the AES job arbiter.
//   r0_* / r1_* - per-requester job offer (valid/ready, text, key, inv)
//   rsp_*       - result port (valid/ready, data, id, err)
// master: job producer / result consumer side. slave: the arbiter.
interface aes_job_arbiter_if;
    import aes_ctrl_pkg::*;

    logic     r0_valid;
    logic     r0_ready;
    aes_blk_t r0_text;
    aes_blk_t r0_key;
    logic     r0_inv;

    logic     r1_valid;
    logic     r1_ready;
    aes_blk_t r1_text;
    aes_blk_t r1_key;
    logic     r1_inv;

    logic     rsp_valid;
    logic     rsp_ready;
    aes_blk_t rsp_data;
    logic     rsp_id;
    logic     rsp_err;

    modport master (
        output r0_valid, r0_text, r0_key, r0_inv,
        input  r0_ready,
        output r1_valid, r1_text, r1_key, r1_inv,
        input  r1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  r0_valid, r0_text, r0_key, r0_inv,
        output r0_ready,
        input  r1_valid, r1_text, r1_key, r1_inv,
        output r1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/aes_job_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   req  - request vector, bit N = requester N
//   last - 1 when requester 1 was granted most recently
//   gnt  - one-hot grant (or zero when nothing requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the requester that did not win last time gets the grant.
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES_128 core between two job requesters.
//   clk, rst        - clock and synchronous active-high reset
//   bus (slave)     - two job ports and the result port
//   core_rst_n      - registered active-low reset to the core
//   core_plaintext  - latched operand to the core
//   core_key        - latched key to the core
//   core_inv_en     - latched direction (1 = decrypt)
//   core_ciphertext - core result
//   core_done       - core one-cycle done pulse
// The core loads its operand while in reset and starts on release, so it is
// kept in reset everywhere except RUN.
module aes_job_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    aes_job_arbiter_if.slave  bus,
    output logic              core_rst_n,
    output aes_blk_t          core_plaintext,
    output aes_blk_t          core_key,
    output logic              core_inv_en,
    input  aes_blk_t          core_ciphertext,
    input  logic              core_done
);

    localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WdMax  = '1;

    aes_ctrl_state_e  state_q, state_d;
    logic             last_q;
    logic             core_rst_n_q;
    aes_blk_t         pt_q, key_q;
    logic             inv_q;
    logic [CNT_W-1:0] wd_q;
    aes_blk_t         rsp_data_q;
    logic             rsp_id_q, rsp_err_q;

    logic [1:0]       gnt;
    logic             accept;
    logic             wd_expired;

    rr_arb2 u_arb (
        .req  ({bus.r1_valid, bus.r0_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign accept     = (state_q == StIdle) && (gnt != 2'b00);
    assign wd_expired = (wd_q == WdLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (core_done || wd_expired) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.r0_ready  = 1'b0;
        bus.r1_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            StIdle: begin
                bus.r0_ready = gnt[0];
                bus.r1_ready = gnt[1];
            end
            StResp:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, watchdog, result capture and core reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;
            core_rst_n_q <= 1'b0;
            pt_q         <= '0;
            key_q        <= '0;
            inv_q        <= 1'b0;
            wd_q         <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            // Registered so the core sees a glitch-free reset: high only in RUN.
            core_rst_n_q <= (state_d == StRun);

            if (accept) begin
                last_q   <= gnt[1];
                rsp_id_q <= gnt[1];
                pt_q     <= gnt[1] ? bus.r1_text : bus.r0_text;
                key_q    <= gnt[1] ? bus.r1_key  : bus.r0_key;
                inv_q    <= gnt[1] ? bus.r1_inv  : bus.r0_inv;
            end

            if (state_q == StLoad) begin
                wd_q <= '0;
            end else if (state_q == StRun && wd_q != WdMax) begin
                wd_q <= wd_q + 1'b1;
            end

            // A done pulse on the last watchdog cycle still counts as success.
            if (state_q == StRun) begin
                if (core_done) begin
                    rsp_data_q <= core_ciphertext;
                    rsp_err_q  <= 1'b0;
                end else if (wd_expired) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
        end
    end

    assign core_rst_n     = core_rst_n_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign core_inv_en    = inv_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: self-checking bench for aes_job_arbiter with a stub core.
// The stub pulses done a programmable number of RUN cycles after reset
// release and returns a known AES vector or a simple mix of its operands.
module tb_aes_job_arbiter;
    import aes_ctrl_pkg::*;

    localparam int unsigned TO = 8;

    localparam aes_blk_t KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_blk_t PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_blk_t CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_blk_t KEY1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam aes_blk_t PT1  = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam aes_blk_t KEY2 = 128'h55555555aaaaaaaa33333333cccccccc;
    localparam aes_blk_t PT2  = 128'h0badc0de1122334455667788feedface;
    localparam aes_blk_t PT3  = 128'h13579bdf2468ace0fedcba9876543210;

    typedef struct packed {
        logic     id;
        aes_blk_t data;
        logic     err;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     core_rst_n, core_inv_en, core_done;
    aes_blk_t core_plaintext, core_key, core_ciphertext;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    int run_cnt  = 0;
    bit done_en  = 1'b1;
    int done_lat = 3;

    always #5 clk = ~clk;

    aes_job_arbiter_if bus ();

    aes_job_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .core_rst_n      (core_rst_n),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_inv_en     (core_inv_en),
        .core_ciphertext (core_ciphertext),
        .core_done       (core_done)
    );

    function automatic aes_blk_t stub_core(aes_blk_t t, aes_blk_t k, logic inv);
        if (!inv && k == KEY0 && t == PT0) return CT0;
        if (inv && k == KEY0 && t == CT0) return PT0;
        return {t[63:0], t[127:64]} ^ k ^ {128{inv}};
    endfunction

    // Stub core: counts cycles out of reset, pulses done on cycle done_lat-1.
    always @(posedge clk) run_cnt <= core_rst_n ? run_cnt + 1 : 0;
    assign core_done       = core_rst_n && done_en && (run_cnt == done_lat - 1);
    assign core_ciphertext = stub_core(core_plaintext, core_key, core_inv_en);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts cycles since the handshake edge; start is the current offset.
    task automatic wait_rsp(input int start, output int lat, output bit ok);
        lat = start;
        ok  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
            lat++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_core_rst_n got=%0b exp=0", core_rst_n);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_rsp got v=%0b e=%0b id=%0b d=%h exp all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data);
        end
        checks++;
        if ({core_plaintext, core_key, core_inv_en} !== '0) begin
            failures++;
            $display("FAIL reset_core_ops got pt=%h k=%h inv=%0b exp 0",
                     core_plaintext, core_key, core_inv_en);
        end
        checks++;
        if (dut.last_q !== 1'b1) begin
            failures++;
            $display("FAIL reset_last got=%0b exp=1", dut.last_q);
        end
        checks++;
        if (dut.state_q !== StIdle || dut.wd_q !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got st=%0d wd=%0d exp st=0 wd=0", dut.state_q, dut.wd_q);
        end
        checks++;
        if ({bus.r1_ready, bus.r0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {bus.r1_ready, bus.r0_ready});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_encrypt();
        int   lat;
        bit   ok;
        exp_t e;
        done_en = 1'b1;
        done_lat = 3;
        bus.r0_text = PT0;
        bus.r0_key = KEY0;
        bus.r0_inv = 1'b0;
        bus.r0_valid = 1'b1;
        #1;
        checks++;
        if ({bus.r1_ready, bus.r0_ready} !== 2'b01 || core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got rdy=%b crst=%0b exp rdy=01 crst=0",
                     {bus.r1_ready, bus.r0_ready}, core_rst_n);
        end
        sb.push_back('{id: 1'b0, data: CT0, err: 1'b0});
        tick();
        bus.r0_valid = 1'b0;
        checks++;
        if (core_rst_n !== 1'b0 || {core_plaintext, core_key, core_inv_en} !== {PT0, KEY0, 1'b0}) begin
            failures++;
            $display("FAIL single_load got crst=%0b pt=%h k=%h inv=%0b exp crst=0 pt=%h k=%h inv=0",
                     core_rst_n, core_plaintext, core_key, core_inv_en, PT0, KEY0);
        end
        tick();
        checks++;
        if (core_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL single_run_rst got=%0b exp=1", core_rst_n);
        end
        wait_rsp(2, lat, ok);
        checks++;
        if (!ok || lat != 2 + 3) begin
            failures++;
            $display("FAIL single_latency got ok=%0b lat=%0d exp ok=1 lat=5", ok, lat);
        end
        pop_exp(e);
        checks++;
        if (core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL single_resp_rst got=%0b exp=0", core_rst_n);
        end
        checks++;
        if (bus.rsp_data !== e.data) begin
            failures++;
            $display("FAIL single_data got=%h exp=%h", bus.rsp_data, e.data);
        end
        checks++;
        if ({bus.rsp_id, bus.rsp_err} !== {e.id, e.err}) begin
            failures++;
            $display("FAIL single_id_err got id=%0b err=%0b exp id=%0b err=%0b",
                     bus.rsp_id, bus.rsp_err, e.id, e.err);
        end
        release_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0 || core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL single_after got v=%0b crst=%0b exp v=0 crst=0", bus.rsp_valid, core_rst_n);
        end
    endtask

    task automatic test_back_to_back_tie();
        int   lat;
        bit   ok;
        exp_t e;
        logic exp_id;
        done_lat = 2;
        bus.r0_text = PT1;
        bus.r0_key = KEY1;
        bus.r0_inv = 1'b0;
        bus.r1_text = PT2;
        bus.r1_key = KEY2;
        bus.r1_inv = 1'b1;
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp_id = (j % 2 == 1);
            checks++;
            if ({bus.r1_ready, bus.r0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL tie_grant job=%0d got=%b exp=%b", j,
                         {bus.r1_ready, bus.r0_ready}, exp_id ? 2'b10 : 2'b01);
            end
            sb.push_back('{id: exp_id,
                           data: exp_id ? stub_core(PT2, KEY2, 1'b1) : stub_core(PT1, KEY1, 1'b0),
                           err: 1'b0});
            tick();
            wait_rsp(1, lat, ok);
            pop_exp(e);
            checks++;
            if (!ok || bus.rsp_id !== e.id || bus.rsp_err !== e.err) begin
                failures++;
                $display("FAIL tie_id job=%0d got ok=%0b id=%0b err=%0b exp id=%0b err=%0b",
                         j, ok, bus.rsp_id, bus.rsp_err, e.id, e.err);
            end
            checks++;
            if (bus.rsp_data !== e.data) begin
                failures++;
                $display("FAIL tie_data job=%0d got=%h exp=%h", j, bus.rsp_data, e.data);
            end
            checks++;
            if ({bus.r1_ready, bus.r0_ready} !== 2'b00) begin
                failures++;
                $display("FAIL tie_busy_ready job=%0d got=%b exp=00", j, {bus.r1_ready, bus.r0_ready});
            end
            release_rsp();
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   ok;
        exp_t e;
        done_lat = 4;
        bus.r1_text = PT3;
        bus.r1_key = KEY2;
        bus.r1_inv = 1'b1;
        bus.r1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.r1_ready, bus.r0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=10", {bus.r1_ready, bus.r0_ready});
        end
        sb.push_back('{id: 1'b1, data: stub_core(PT3, KEY2, 1'b1), err: 1'b0});
        tick();
        bus.r0_valid = 1'b1;
        wait_rsp(1, lat, ok);
        checks++;
        if (!ok || lat != 2 + 4) begin
            failures++;
            $display("FAIL bp_latency got ok=%0b lat=%0d exp ok=1 lat=6", ok, lat);
        end
        pop_exp(e);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, core_rst_n,
                 bus.r1_ready, bus.r0_ready} !== {1'b1, e.data, e.id, e.err, 1'b0, 2'b00}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%0b d=%h id=%0b err=%0b crst=%0b rdy=%b exp v=1 d=%h id=%0b err=%0b crst=0 rdy=00",
                         i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err, core_rst_n,
                         {bus.r1_ready, bus.r0_ready}, e.data, e.id, e.err);
            end
            tick();
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        release_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got v=%0b exp v=0", bus.rsp_valid);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   lat;
        bit   ok;
        exp_t e;
        done_en = 1'b0;
        bus.r0_text = PT1;
        bus.r0_key = KEY1;
        bus.r0_inv = 1'b0;
        bus.r0_valid = 1'b1;
        sb.push_back('{id: 1'b0, data: '0, err: 1'b1});
        tick();
        bus.r0_valid = 1'b0;
        wait_rsp(1, lat, ok);
        pop_exp(e);
        checks++;
        if (!ok || lat != 2 + TO) begin
            failures++;
            $display("FAIL timeout_latency got ok=%0b lat=%0d exp ok=1 lat=%0d", ok, lat, 2 + TO);
        end
        checks++;
        if ({bus.rsp_data, bus.rsp_id, bus.rsp_err} !== {e.data, e.id, e.err}) begin
            failures++;
            $display("FAIL timeout_rsp got d=%h id=%0b err=%0b exp d=%h id=%0b err=%0b",
                     bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
        end
        release_rsp();
        done_en = 1'b1;
        tick();
    endtask

    task automatic test_coincidence();
        int   lat;
        bit   ok;
        exp_t e;
        done_lat = TO;
        bus.r1_text = PT2;
        bus.r1_key = KEY2;
        bus.r1_inv = 1'b1;
        bus.r1_valid = 1'b1;
        sb.push_back('{id: 1'b1, data: stub_core(PT2, KEY2, 1'b1), err: 1'b0});
        tick();
        bus.r1_valid = 1'b0;
        wait_rsp(1, lat, ok);
        pop_exp(e);
        checks++;
        if (!ok || lat != 2 + TO) begin
            failures++;
            $display("FAIL coinc_latency got ok=%0b lat=%0d exp ok=1 lat=%0d", ok, lat, 2 + TO);
        end
        checks++;
        if (bus.rsp_err !== e.err || bus.rsp_id !== e.id) begin
            failures++;
            $display("FAIL coinc_err got err=%0b id=%0b exp err=%0b id=%0b",
                     bus.rsp_err, bus.rsp_id, e.err, e.id);
        end
        checks++;
        if (bus.rsp_data !== e.data) begin
            failures++;
            $display("FAIL coinc_data got=%h exp=%h", bus.rsp_data, e.data);
        end
        release_rsp();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        bit   ok;
        bit   seen;
        exp_t e;
        done_lat = 5;
        bus.r0_text = PT1;
        bus.r0_key = KEY1;
        bus.r0_inv = 1'b0;
        bus.r0_valid = 1'b1;
        tick();
        bus.r0_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut.state_q !== StIdle || dut.last_q !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state got st=%0d last=%0b exp st=0 last=1", dut.state_q, dut.last_q);
        end
        checks++;
        if (core_rst_n !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got crst=%0b v=%0b exp crst=0 v=0", core_rst_n, bus.rsp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_rsp got seen=%0b exp=0", seen);
        end
        bus.r1_text = PT2;
        bus.r1_key = KEY2;
        bus.r1_inv = 1'b1;
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.r1_ready, bus.r0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midrst_tie got=%b exp=01", {bus.r1_ready, bus.r0_ready});
        end
        sb.push_back('{id: 1'b0, data: stub_core(PT1, KEY1, 1'b0), err: 1'b0});
        tick();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_rsp(1, lat, ok);
        pop_exp(e);
        checks++;
        if (!ok || {bus.rsp_data, bus.rsp_id, bus.rsp_err} !== {e.data, e.id, e.err}) begin
            failures++;
            $display("FAIL midrst_job got ok=%0b d=%h id=%0b err=%0b exp d=%h id=%0b err=%0b",
                     ok, bus.rsp_data, bus.rsp_id, bus.rsp_err, e.data, e.id, e.err);
        end
        release_rsp();
        tick();
    endtask

    initial begin
        bus.r0_valid  = 1'b0;
        bus.r0_text   = '0;
        bus.r0_key    = '0;
        bus.r0_inv    = 1'b0;
        bus.r1_valid  = 1'b0;
        bus.r1_text   = '0;
        bus.r1_key    = '0;
        bus.r1_inv    = 1'b0;
        bus.rsp_ready = 1'b0;

        test_reset();
        test_single_encrypt();
        test_back_to_back_tie();
        test_backpressure();
        test_timeout();
        test_coincidence();
        test_reset_mid_run();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
